// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (default 115200 baud at 50 MHz).
//
// Synchronises the serial line, validates the start bit at mid-bit, samples
// eight data bits LSB-first at bit centres and checks the stop bit. Each good
// byte is presented with a one-cycle rx_valid strobe. A low stop bit gives a
// one-cycle rx_frame_err strobe instead.
//
// Ports:
//   hs_clk        in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   uart_rxd      in   asynchronous serial line, idle high
//   rx_data       out  [7:0] last correctly framed byte, held until next one
//   rx_valid      out  one-cycle pulse, rx_data is new this cycle
//   rx_frame_err  out  one-cycle pulse, stop bit sampled low
//   rx_busy       out  high while a frame is in progress
//
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes the
// 2-of-3 vote of rxd_s2 at (point-2, point-1, point), which rejects a
// single-cycle glitch at the sample point. Undefined: single sample.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       hs_clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} state_t;

  state_t      state_q, state_d;
  logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic        rxd_s1_d, rxd_s2_d, rxd_s3_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic        fall_edge;
  logic        bit_val;
  logic        start_hit, bit_hit;

  // Three-flop synchroniser; s3 exists only for edge detection.
  always_comb begin
    rxd_s1_d = uart_rxd;
    rxd_s2_d = rxd_s1_q;
    rxd_s3_d = rxd_s2_q;
  end

  assign fall_edge = rxd_s3_q & ~rxd_s2_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[1] holds rxd_s2 from two cycles back, hist_q[0] from one.
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rxd_s2_q};

  always_ff @(posedge hs_clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s2_q) |
                   (hist_q[0] & rxd_s2_q);
`else
  assign bit_val = rxd_s2_q;
`endif

  assign start_hit = (baud_cnt_q == HALF_LAST);
  assign bit_hit   = (baud_cnt_q == BIT_LAST);

  // State register
  always_ff @(posedge hs_clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall_edge) state_d = RX_START;
      // A high sample at mid start bit is a glitch, not a frame.
      RX_START: if (start_hit) state_d = bit_val ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_idx_q == 3'd7) state_d = RX_STOP;
      // Leave at stop-bit centre so a back-to-back start edge is seen.
      RX_STOP:  if (bit_hit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    baud_cnt_d = baud_cnt_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_cnt_d = 16'd0;
        bit_idx_d  = 3'd0;
      end
      RX_START: begin
        if (start_hit) baud_cnt_d = 16'd0;
      end
      RX_DATA: begin
        if (bit_hit) begin
          baud_cnt_d = 16'd0;
          shift_d    = {bit_val, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (bit_hit) begin
          baud_cnt_d = 16'd0;
          if (bit_val) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_ferr_d  = 1'b1;
          end
        end
      end
      default: baud_cnt_d = 16'd0;
    endcase
  end

  always_ff @(posedge hs_clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rxd_s3_q   <= rxd_s3_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Outputs
  always_comb begin
    rx_busy      = (state_q != RX_IDLE);
    rx_data      = rx_data_q;
    rx_valid     = rx_valid_q;
    rx_frame_err = rx_ferr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx at 434 clocks per bit.
// A negedge monitor counts strobes, logs received bytes and busy cycles;
// the stimulus thread drives frames and checks results through chk().
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT = 434;

  logic       hs_clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx dut (
    .hs_clk       (hs_clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 hs_clk = ~hs_clk;

  int n_chk = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int busy_cyc = 0;
  int valid_cyc = 0;
  int bit_cyc = 0;
  int start_cyc = 0;
  logic [7:0] rxq[$];

  always @(posedge hs_clk) cyc <= cyc + 1;

  always @(negedge hs_clk) begin
    if (rx_valid) begin
      n_valid++;
      valid_cyc = cyc;
      rxq.push_back(rx_data);
    end
    if (rx_frame_err) n_err++;
    if (rx_valid && rx_frame_err) n_both++;
    if (rx_busy) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge hs_clk);
  endtask

  // Drive one bit for a full bit time; optional 1-cycle inversion at centre.
  task automatic drive_bit(input logic v, input logic g);
    for (int c = 0; c < BIT; c++) begin
      @(negedge hs_clk);
      if (c == 0) bit_cyc = cyc;
      uart_rxd = (g && c == BIT / 2) ? ~v : v;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic g);
    drive_bit(1'b0, 1'b0);
    start_cyc = bit_cyc;
    for (int i = 0; i < 8; i++) drive_bit(b[i], g);
    drive_bit(stop, 1'b0);
  endtask

  initial begin
    int lat;
    int v0, e0;
    logic [7:0] f0;
    rst = 1'b1;
    uart_rxd = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(1000);

    // Reset state on an idle line
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_ferr",  32'(rx_frame_err), 0);
    chk("rst_busy",  32'(rx_busy), 0);

    // Single frame 0x55
    send_byte(8'h55, 1'b1, 1'b0);
    idle(300);
    lat = valid_cyc - start_cyc;
    chk("f55_count", 32'(n_valid), 1);
    chk("f55_data",  32'(rx_data), 32'h55);
    chk("f55_lat",   32'(lat >= 4124 && lat <= 4128), 1);
    chk("f55_noerr", 32'(n_err), 0);

    // Stop bit low then line stuck low: one error, data held
    send_byte(8'h3C, 1'b0, 1'b0);
    idle(2000);
    uart_rxd = 1'b1;
    idle(1000);
    chk("ferr_count",  32'(n_err), 1);
    chk("ferr_nvalid", 32'(n_valid), 1);
    chk("ferr_data",   32'(rx_data), 32'h55);
    chk("ferr_busy",   32'(rx_busy), 0);

    // Back-to-back frames with no idle gap
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    idle(300);
    chk("b2b_count", 32'(n_valid), 3);
    chk("b2b_d0",    32'(rxq[1]), 32'hA5);
    chk("b2b_d1",    32'(rxq[2]), 32'h3C);
    chk("b2b_noerr", 32'(n_err), 1);

    // 100-cycle low glitch: busy for about half a bit, no strobes
    busy_cyc = 0;
    v0 = n_valid;
    e0 = n_err;
    for (int c = 0; c < 100; c++) begin
      @(negedge hs_clk);
      uart_rxd = 1'b0;
    end
    @(negedge hs_clk);
    uart_rxd = 1'b1;
    idle(1000);
    chk("glitch_busy", 32'(busy_cyc >= 215 && busy_cyc <= 219), 1);
    chk("glitch_nval", 32'(n_valid - v0), 0);
    chk("glitch_nerr", 32'(n_err - e0), 0);

    // Reset during bit 4 of 0xF0, then a clean 0x81
    f0 = 8'hF0;
    v0 = n_valid;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(f0[i], 1'b0);
    idle(BIT / 2);
    rst = 1'b1;
    idle(3);
    chk("mid_rst_busy", 32'(rx_busy), 0);
    chk("mid_rst_data", 32'(rx_data), 32'h00);
    rst = 1'b0;
    uart_rxd = 1'b1;
    idle(1000);
    chk("abort_nval", 32'(n_valid - v0), 0);
    send_byte(8'h81, 1'b1, 1'b0);
    idle(300);
    chk("f81_count", 32'(n_valid - v0), 1);
    chk("f81_data",  32'(rx_data), 32'h81);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle inverted glitch at each data-bit centre is voted out
    v0 = n_valid;
    send_byte(8'h81, 1'b1, 1'b1);
    idle(300);
    chk("maj_count", 32'(n_valid - v0), 1);
    chk("maj_data",  32'(rx_data), 32'h81);
`endif

    chk("never_both", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
